// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths and bus field widths used by the arbiter,
// the reservation stations and the result listeners.
package cdb_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 4;
    localparam int unsigned DEFAULT_CDB_TAG_WIDTH = 4;
    localparam int unsigned DEFAULT_N_PRODUCERS   = 4;

    // Field widths of the broadcast bus {valid, tag, data}.
    localparam int unsigned CDB_VALID_FIELD_W = 1;
    localparam int unsigned CDB_TAG_FIELD_W   = DEFAULT_CDB_TAG_WIDTH;
    localparam int unsigned CDB_DATA_FIELD_W  = DEFAULT_DATA_WIDTH;
    localparam int unsigned CDB_BUS_W         = CDB_VALID_FIELD_W + CDB_TAG_FIELD_W + CDB_DATA_FIELD_W;

    // Width of an index into n producers, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_rr_priority_select.sv
// Combinational circular priority search: the first requesting index at or after
// start_i (wrapping at N-1) wins and is reported one-hot and as a binary index.
module cdb_rr_priority_select
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N_PRODUCERS,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_grant_o
);

    int unsigned idx;

    // NOTE: every output and temporary gets a default before the search loop, so no
    // path through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(start_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one producer per cycle and registers its result
// onto the CDB one cycle later. Define CDB_ARBITER_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest requesting index wins.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned CDB_TAG_WIDTH = DEFAULT_CDB_TAG_WIDTH,
    parameter int unsigned N_PRODUCERS   = DEFAULT_N_PRODUCERS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              hold,
    input  logic [N_PRODUCERS-1:0]            req,
    input  logic [N_PRODUCERS*DATA_WIDTH-1:0] req_data,
    output logic [N_PRODUCERS-1:0]            accepted,
    output logic                              cdb_valid,
    output logic [CDB_TAG_WIDTH-1:0]          cdb_tag,
    output logic [DATA_WIDTH-1:0]             cdb_data
);

    localparam int unsigned PTR_W = idx_width(N_PRODUCERS);

    logic                     grant_en;
    logic [N_PRODUCERS-1:0]   req_masked;
    logic [N_PRODUCERS-1:0]   grant;
    logic [PTR_W-1:0]         grant_idx;
    logic                     any_grant;
    logic [PTR_W-1:0]         start;

    logic                     valid_q, valid_d;
    logic [CDB_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;

    // Reset and hold suppress the grant in the same cycle, not just the broadcast.
    assign grant_en   = ~hold & ~rst;
    assign req_masked = req & {N_PRODUCERS{grant_en}};

`ifdef CDB_ARBITER_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign start = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = (int'(grant_idx) == N_PRODUCERS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    cdb_rr_priority_select #(
        .N     (N_PRODUCERS),
        .IDX_W (PTR_W)
    ) u_select (
        .req_i       (req_masked),
        .start_i     (start),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    assign accepted = grant;

    // Tag and data hold their last broadcast value when nothing is granted.
    always_comb begin
        valid_d = any_grant;
        tag_d   = tag_q;
        data_d  = data_q;
        if (any_grant) begin
            tag_d = CDB_TAG_WIDTH'(grant_idx);
        end
        for (int unsigned i = 0; i < N_PRODUCERS; i++) begin
            if (grant[i]) begin
                data_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the always_ff blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter at default parameters; expectations follow the
// arbitration mode selected by CDB_ARBITER_ROUND_ROBIN_EN.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  accepted;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [3:0]  cdb_data;

    int total = 0;
    int bad   = 0;
    int exp_idx;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req       (req),
        .req_data  (req_data),
        .accepted  (accepted),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic v, input logic [3:0] t, input logic [3:0] d);
        check({tag, "_valid"}, 32'(cdb_valid), 32'(v));
        check({tag, "_tag"},   32'(cdb_tag),   32'(t));
        check({tag, "_data"},  32'(cdb_data),  32'(d));
    endtask

    initial begin
        // Reset held two cycles with every producer requesting.
        rst = 1'b1; hold = 1'b0; req = 4'b1111; req_data = 16'h4321;
        #1;
        check("rst_acc0", 32'(accepted), 32'h0);
        tick();
        check("rst_acc1", 32'(accepted), 32'h0);
        check_bus("rst1", 1'b0, 4'h0, 4'h0);
        tick();
        check("rst_acc2", 32'(accepted), 32'h0);
        check_bus("rst2", 1'b0, 4'h0, 4'h0);

        // Single request, then idle: tag/data must hold while valid drops.
        rst = 1'b0; req = 4'b0100; req_data = 16'h0A00;
        #1;
        check("single_acc", 32'(accepted), 32'h4);
        tick();
        check_bus("single", 1'b1, 4'h2, 4'hA);
        req = 4'b0000;
        #1;
        check("idle_acc", 32'(accepted), 32'h0);
        tick();
        check_bus("idle", 1'b0, 4'h2, 4'hA);

        // Full contention from reset, five back-to-back grants.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111; req_data = 16'h4321;
        for (int c = 0; c < 5; c++) begin
`ifdef CDB_ARBITER_ROUND_ROBIN_EN
            exp_idx = c % 4;
`else
            exp_idx = 0;
`endif
            #1;
            check($sformatf("cont%0d_acc", c), 32'(accepted), 32'(1 << exp_idx));
            tick();
            check_bus($sformatf("cont%0d", c), 1'b1, 4'(exp_idx), 4'(exp_idx + 1));
        end

`ifndef CDB_ARBITER_ROUND_ROBIN_EN
        // Fixed priority: lowest requester always wins.
        req = 4'b1010; req_data = 16'h70B0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("fixed%0d_acc", c), 32'(accepted), 32'h2);
            tick();
            check_bus($sformatf("fixed%0d", c), 1'b1, 4'h1, 4'hB);
        end
`endif

        // Hold from reset: no grant while held, grant on first released cycle.
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0; req = 4'b0001; req_data = 16'h0005; hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("hold%0d_acc", c), 32'(accepted), 32'h0);
            tick();
            check($sformatf("hold%0d_valid", c), 32'(cdb_valid), 32'h0);
        end
        hold = 1'b0;
        #1;
        check("unhold_acc", 32'(accepted), 32'h1);
        tick();
        check_bus("unhold", 1'b1, 4'h0, 4'h5);

        // Move the pointer to 3, then wrap, then reset mid-broadcast.
        req = 4'b0100; req_data = 16'h9C5E;
        #1;
        check("pre_wrap_acc", 32'(accepted), 32'h4);
        tick();
        check_bus("pre_wrap", 1'b1, 4'h2, 4'hC);
        req = 4'b1001;
        #1;
`ifdef CDB_ARBITER_ROUND_ROBIN_EN
        check("wrap_acc", 32'(accepted), 32'h8);
        tick();
        check_bus("wrap", 1'b1, 4'h3, 4'h9);
`else
        check("wrap_acc", 32'(accepted), 32'h1);
        tick();
        check_bus("wrap", 1'b1, 4'h0, 4'hE);
`endif
        rst = 1'b1;
        #1;
        check("midrst_acc", 32'(accepted), 32'h0);
        tick();
        check_bus("midrst", 1'b0, 4'h0, 4'h0);
        rst = 1'b0;
        #1;
        check("postrst_acc", 32'(accepted), 32'h1);
        tick();
        check_bus("postrst", 1'b1, 4'h0, 4'hE);

        // Hold must not advance the pointer (now 1 in round-robin mode).
        req = 4'b1111; req_data = 16'h4321; hold = 1'b1;
        #1;
        check("hold_ptr_acc", 32'(accepted), 32'h0);
        tick();
        check("hold_ptr_valid", 32'(cdb_valid), 32'h0);
        hold = 1'b0;
        #1;
`ifdef CDB_ARBITER_ROUND_ROBIN_EN
        check("after_hold_acc", 32'(accepted), 32'h2);
        tick();
        check_bus("after_hold", 1'b1, 4'h1, 4'h2);
`else
        check("after_hold_acc", 32'(accepted), 32'h1);
        tick();
        check_bus("after_hold", 1'b1, 4'h0, 4'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
